// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: default widths and the
// response-selector encoding.
package cpu_pkg;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_I    = 2'd1,
    RESP_D    = 2'd2
  } resp_sel_e;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of D grants that passed a waiting I request; force_i_o
// asserts once the limit is reached so the I-port wins the next contention.
module starve_counter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic force_i_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != 4'(STARVE_MAX)))
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign force_i_o = (cnt_q == 4'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous memory between the fetch (I) and
// load/store (D) requesters and routes the one-cycle-late read data back.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          i_flush,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  resp_sel_e resp_q, resp_d;
  logic      flush_q;
  logic      force_i;
  logic      unused_byte_bits;

  assign unused_byte_bits = ^{i_addr[1:0], d_addr[1:0]};

  starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk_i     (clk),
    .rst_i     (rst),
    .inc_i     (d_gnt & i_req),
    .clr_i     (i_gnt | ~i_req),
    .force_i_o (force_i)
  );

  // Grants are held off during reset so the memory port stays quiet.
  always_comb begin
    i_gnt = ~rst & i_req & (~d_req | force_i);
    d_gnt = ~rst & d_req & ~(i_req & force_i);
  end

  always_comb begin
    mem_en    = i_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr[AW-1:2];
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = i_addr[AW-1:2];
    end
  end

  always_comb begin
    resp_d = RESP_NONE;
    if (i_gnt)
      resp_d = RESP_I;
    else if (d_gnt && !d_we)
      resp_d = RESP_D;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q  <= RESP_NONE;
      flush_q <= 1'b0;
    end else begin
      resp_q  <= resp_d;
      flush_q <= i_flush & i_gnt;
    end
  end

  // A flush in the return cycle squashes the fetch already awaiting return.
  always_comb begin
    i_rvalid = (resp_q == RESP_I) & ~flush_q & ~i_flush;
    d_rvalid = (resp_q == RESP_D);
    i_rdata  = mem_rdata;
    d_rdata  = mem_rdata;
  end

endmodule
